// File: rtl/lbm_pkg.sv
// lbm_pkg: D2Q9 direction tables, cell payload type and streamer FSM states.
package lbm_pkg;

    localparam int unsigned NUM_DIRS = 9;
    localparam int unsigned LANE_W   = 4;

    // Direction indices double as byte-lane indices of a cell word.
    localparam logic [LANE_W-1:0] DIR_C  = 4'd0;
    localparam logic [LANE_W-1:0] DIR_N  = 4'd1;
    localparam logic [LANE_W-1:0] DIR_NE = 4'd2;
    localparam logic [LANE_W-1:0] DIR_E  = 4'd3;
    localparam logic [LANE_W-1:0] DIR_SE = 4'd4;
    localparam logic [LANE_W-1:0] DIR_S  = 4'd5;
    localparam logic [LANE_W-1:0] DIR_SW = 4'd6;
    localparam logic [LANE_W-1:0] DIR_W  = 4'd7;
    localparam logic [LANE_W-1:0] DIR_NW = 4'd8;

    // Row 0 is the top edge, so north is dy = -1.
    localparam int DIR_DX [NUM_DIRS] = '{0,  0,  1, 1, 1, 0, -1, -1, -1};
    localparam int DIR_DY [NUM_DIRS] = '{0, -1, -1, 0, 1, 1,  1,  0, -1};

    // Bounce-back reverses the travel direction.
    localparam logic [LANE_W-1:0] OPP [NUM_DIRS] =
        '{DIR_C, DIR_S, DIR_SW, DIR_W, DIR_NW, DIR_N, DIR_NE, DIR_E, DIR_SE};

    typedef logic [NUM_DIRS-1:0][7:0] cell_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SCATTER = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/lattice_neighbor_addr.sv
// lattice_neighbor_addr: target address and byte lane for one direction of a cell.
// Edge handling is bounce-back unless LATTICE_STREAMER_PERIODIC_WRAP_EN is defined,
// in which case targets wrap toroidally. Offsets are constants; no multiplier.
module lattice_neighbor_addr
    import lbm_pkg::*;
#(
    parameter int unsigned WIDTH  = 205,
    parameter int unsigned HEIGHT = 154,
    parameter int unsigned ADDR_W = $clog2(WIDTH * HEIGHT),
    parameter int unsigned X_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned Y_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LANE_W-1:0] dir_in,
    output logic [ADDR_W-1:0] addr_c,
    output logic [LANE_W-1:0] lane_c
);

    int dx;
    int dy;
    int nx;
    int ny;
    int x_off;
    int y_off;

    // Resolve the neighbour of (x, y) in direction dir, applying the edge rule.
    always_comb begin
        dx = 0;
        dy = 0;
        if (dir_in < LANE_W'(NUM_DIRS)) begin
            dx = DIR_DX[dir_in];
            dy = DIR_DY[dir_in];
        end
        nx    = int'(x_in) + dx;
        ny    = int'(y_in) + dy;
        x_off = dx;
        y_off = (dy < 0) ? -int'(WIDTH) : ((dy > 0) ? int'(WIDTH) : 0);
`ifdef LATTICE_STREAMER_PERIODIC_WRAP_EN
        if (nx < 0) begin
            x_off = x_off + int'(WIDTH);
        end else if (nx >= int'(WIDTH)) begin
            x_off = x_off - int'(WIDTH);
        end
        if (ny < 0) begin
            y_off = y_off + int'(WIDTH * HEIGHT);
        end else if (ny >= int'(HEIGHT)) begin
            y_off = y_off - int'(WIDTH * HEIGHT);
        end
        addr_c = ADDR_W'(int'(base_in) + x_off + y_off);
        lane_c = dir_in;
`else
        if ((nx < 0) || (nx >= int'(WIDTH)) || (ny < 0) || (ny >= int'(HEIGHT))) begin
            addr_c = base_in;
            lane_c = (dir_in < LANE_W'(NUM_DIRS)) ? OPP[dir_in] : DIR_C;
        end else begin
            addr_c = ADDR_W'(int'(base_in) + x_off + y_off);
            lane_c = dir_in;
        end
`endif
    end

endmodule

// File: rtl/lattice_streamer.sv
// lattice_streamer: LBM streaming step. Reads each source cell in raster order and
// scatters its 9 populations to the destination BRAM, one byte lane per cycle.
// Compile option: LATTICE_STREAMER_PERIODIC_WRAP_EN selects toroidal wrap at the
// lattice edges instead of bounce-back. Outputs are registered from next-state values.
module lattice_streamer
    import lbm_pkg::*;
#(
    parameter int unsigned WIDTH        = 205,
    parameter int unsigned HEIGHT       = 154,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_W       = $clog2(WIDTH * HEIGHT)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    output logic [ADDR_W-1:0]   rd_addr_out,
    input  cell_t               rd_data_in,
    output logic [ADDR_W-1:0]   wr_addr_out,
    output cell_t               wr_data_out,
    output logic [NUM_DIRS-1:0] wr_byte_en_out,
    output logic                wr_en_out,
    output logic                busy_out,
    output logic                done_out
);

    localparam int unsigned X_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned Y_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned WAIT_W = 3;
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
    localparam logic [LANE_W-1:0] DIR_LAST  = LANE_W'(NUM_DIRS - 1);

    state_e               state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [LANE_W-1:0]    dir_q, dir_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    cell_t                cell_q, cell_d;

    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    cell_t                wr_data_q, wr_data_d;
    logic [NUM_DIRS-1:0]  wr_be_q, wr_be_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 last_wait, last_dir, last_cell;
    logic [ADDR_W-1:0]    tgt_addr_c;
    logic [LANE_W-1:0]    tgt_lane_c;

    assign last_wait = (wait_cnt_q == WAIT_LAST);
    assign last_dir  = (dir_q == DIR_LAST);
    assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

    // Target of the write issued next cycle, from next-cycle position and direction.
    lattice_neighbor_addr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_neighbor_addr (
        .x_in    (x_d),
        .y_in    (y_d),
        .base_in (base_d),
        .dir_in  (dir_d),
        .addr_c  (tgt_addr_c),
        .lane_c  (tgt_lane_c)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_in) state_d = ST_READ;
            ST_READ:    state_d = ST_WAIT;
            ST_WAIT:    if (last_wait) state_d = ST_SCATTER;
            ST_SCATTER: if (last_dir) state_d = last_cell ? ST_DONE : ST_READ;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Cell position, running base address, direction and read-wait counters.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        base_d     = base_q;
        dir_d      = dir_q;
        wait_cnt_d = wait_cnt_q;
        cell_d     = cell_q;
        case (state_q)
            ST_READ: wait_cnt_d = '0;
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (last_wait) begin
                    cell_d = rd_data_in;
                    dir_d  = '0;
                end
            end
            ST_SCATTER: begin
                dir_d = dir_q + LANE_W'(1);
                if (last_dir) begin
                    dir_d = '0;
                    if (last_cell) begin
                        x_d    = '0;
                        y_d    = '0;
                        base_d = '0;
                    end else begin
                        base_d = base_q + ADDR_W'(1);
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + Y_W'(1);
                        end else begin
                            x_d = x_q + X_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                x_d    = '0;
                y_d    = '0;
                base_d = '0;
                dir_d  = '0;
            end
            default: ;
        endcase
    end

    // Output decode for the state entered next cycle.
    always_comb begin
        rd_addr_d = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        wr_be_d   = '0;
        wr_en_d   = 1'b0;
        busy_d    = (state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_SCATTER);
        done_d    = (state_d == ST_DONE);
        case (state_d)
            ST_READ: rd_addr_d = base_d;
            ST_SCATTER: begin
                wr_en_d   = 1'b1;
                wr_addr_d = tgt_addr_c;
                wr_be_d   = NUM_DIRS'(1) << tgt_lane_c;
                wr_data_d[tgt_lane_c] = cell_d[dir_d];
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_q        <= '0;
            y_q        <= '0;
            base_q     <= '0;
            dir_q      <= '0;
            wait_cnt_q <= '0;
            cell_q     <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            base_q     <= base_d;
            dir_q      <= dir_d;
            wait_cnt_q <= wait_cnt_d;
            cell_q     <= cell_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_addr_out    = rd_addr_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign wr_byte_en_out = wr_be_q;
    assign wr_en_out      = wr_en_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_lattice_streamer.sv
// tb_lattice_streamer: 4x3 lattice, read latency 2. Source BRAM model, write monitor
// and a coordinate-level reference of the streaming step.
// Honours LATTICE_STREAMER_PERIODIC_WRAP_EN for the edge rule.
`timescale 1ns/1ps
module tb_lattice_streamer;

    localparam int unsigned W        = 4;
    localparam int unsigned H        = 3;
    localparam int unsigned RL       = 2;
    localparam int unsigned AW       = $clog2(W * H);
    localparam int unsigned NC       = W * H;
    localparam int unsigned ND       = 9;
    localparam int unsigned PASS_CYC = NC * (RL + 10);

    logic                clk   = 1'b0;
    logic                rst   = 1'b1;
    logic                start = 1'b0;
    logic [AW-1:0]       rd_addr;
    logic [AW-1:0]       wr_addr;
    logic [8:0][7:0]     rd_data;
    logic [8:0][7:0]     wr_data;
    logic [8:0]          wr_be;
    logic                wr_en;
    logic                busy;
    logic                done;

    int n_vec = 0;
    int n_err = 0;

    // Source memory and its read pipeline.
    logic [8:0][7:0] src [16];
    logic [8:0][7:0] pipe1, pipe2;

    // Monitor-owned destination image.
    logic [7:0] dst  [16][9];
    int         wcnt [16][9];
    int         n_writes;
    int         n_bad;
    int         pass_id = 0;
    int         seen_id = -1;

    // Reference model result.
    logic [7:0] exp_mem [16][9];

    int ddx [9] = '{0,  0,  1, 1, 1, 0, -1, -1, -1};
    int ddy [9] = '{0, -1, -1, 0, 1, 1,  1,  0, -1};

    lattice_streamer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .start_in       (start),
        .rd_addr_out    (rd_addr),
        .rd_data_in     (rd_data),
        .wr_addr_out    (wr_addr),
        .wr_data_out    (wr_data),
        .wr_byte_en_out (wr_be),
        .wr_en_out      (wr_en),
        .busy_out       (busy),
        .done_out       (done)
    );

    always #5 clk = ~clk;

    // Two-cycle source BRAM.
    always @(posedge clk) begin
        pipe1 <= src[rd_addr];
        pipe2 <= pipe1;
    end
    assign rd_data = pipe2;

    // Record every destination write; count malformed strobes.
    always @(negedge clk) begin
        if (pass_id != seen_id) begin
            seen_id  = pass_id;
            n_writes = 0;
            n_bad    = 0;
            for (int a = 0; a < 16; a++)
                for (int l = 0; l < 9; l++) begin
                    dst[a][l]  = 8'h00;
                    wcnt[a][l] = 0;
                end
        end
        if (wr_en) begin
            n_writes++;
            if (!$onehot(wr_be) || (int'(wr_addr) >= NC)) n_bad++;
            for (int l = 0; l < 9; l++) begin
                if (wr_be[l]) begin
                    dst[wr_addr][l]  = wr_data[l];
                    wcnt[wr_addr][l] = wcnt[wr_addr][l] + 1;
                end else if (wr_data[l] != 8'h00) begin
                    n_bad++;
                end
            end
        end else if (wr_be != 9'h000) begin
            n_bad++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_val({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_val({tag, "_wr_data"}, 32'(wr_data != '0), 32'd0);
        check_val({tag, "_wr_be"},   32'(wr_be), 32'd0);
        check_val({tag, "_wr_en"},   32'(wr_en), 32'd0);
        check_val({tag, "_busy"},    32'(busy), 32'd0);
        check_val({tag, "_done"},    32'(done), 32'd0);
    endtask

    // Streaming rule applied in lattice coordinates.
    task automatic build_expected();
        int x, y, nx, ny, ea, el;
        for (int a = 0; a < 16; a++)
            for (int l = 0; l < 9; l++) exp_mem[a][l] = 8'h00;
        for (int c = 0; c < int'(NC); c++) begin
            x = c % int'(W);
            y = c / int'(W);
            for (int d = 0; d < 9; d++) begin
                nx = x + ddx[d];
                ny = y + ddy[d];
                if (nx >= 0 && nx < int'(W) && ny >= 0 && ny < int'(H)) begin
                    ea = ny * int'(W) + nx;
                    el = d;
                end else begin
`ifdef LATTICE_STREAMER_PERIODIC_WRAP_EN
                    ea = ((ny + int'(H)) % int'(H)) * int'(W) + ((nx + int'(W)) % int'(W));
                    el = d;
`else
                    ea = c;
                    el = (d == 0) ? 0 : ((d + 3) % 8) + 1;
`endif
                end
                exp_mem[ea][el] = src[c][d];
            end
        end
    endtask

    task automatic compare_model();
        build_expected();
        for (int a = 0; a < int'(NC); a++)
            for (int l = 0; l < 9; l++) begin
                check_val($sformatf("dst[%0d][%0d]", a, l), 32'(dst[a][l]), 32'(exp_mem[a][l]));
                check_val($sformatf("once[%0d][%0d]", a, l), 32'(wcnt[a][l]), 32'd1);
            end
    endtask

    // One full pass; optional extra start pulse at cycle restart_at.
    task automatic run_pass(input int restart_at);
        int  k;
        bit  seen;
        pass_id++;
        start = 1'b1;
        k     = 0;
        seen  = 1'b0;
        while (k <= int'(PASS_CYC) + 20) begin
            @(negedge clk); #1;
            if (k == 0) begin
                start = 1'b0;
                check_val("busy_at_first_read", 32'(busy), 32'd1);
            end
            if (k == restart_at)          start = 1'b1;
            else if (k == restart_at + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("done_cycle", 32'(k), 32'(PASS_CYC));
        check_val("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk); #1;
        check_val("done_one_cycle", 32'(done), 32'd0);
        check_val("busy_after_done", 32'(busy), 32'd0);
        check_val("write_count", 32'(n_writes), 32'(NC * ND));
        check_val("bad_strobes", 32'(n_bad), 32'd0);
        compare_model();
    endtask

    task automatic fill_random();
        for (int c = 0; c < 16; c++)
            for (int d = 0; d < 9; d++) src[c][d] = 8'($urandom);
    endtask

    // Start a pass, reset it during SCATTER of cell 5, check it stays quiet.
    task automatic abort_pass();
        int snap;
        int abort_k;
        abort_k = 5 * int'(RL + 10) + int'(RL) + 3;
        pass_id++;
        start = 1'b1;
        for (int k = 0; k <= abort_k; k++) begin
            @(negedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        check_val("abort_in_scatter", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        check_idle_outputs("abort");
        rst  = 1'b0;
        snap = n_writes;
        repeat (20) @(negedge clk);
        #1;
        check_val("abort_no_writes", 32'(n_writes - snap), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int c = 0; c < 16; c++) src[c] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk); #1;

        // Random lattice with interior cell (1,1) = 10*dir.
        fill_random();
        for (int d = 0; d < 9; d++) src[5][d] = 8'(10 * d);
        run_pass(-1);
        check_val("int_n",  32'(dst[1][1]), 32'd10);
        check_val("int_e",  32'(dst[6][3]), 32'd30);
        check_val("int_s",  32'(dst[9][5]), 32'd50);
        check_val("int_c",  32'(dst[5][0]), 32'd0);

        // Corner cell (0,0).
        fill_random();
        for (int d = 0; d < 9; d++) src[0][d] = 8'h7F;
`ifdef LATTICE_STREAMER_PERIODIC_WRAP_EN
        src[0][7] = 8'h33;
        run_pass(-1);
        check_val("wrap_w",  32'(dst[3][7]),  32'h33);
        check_val("wrap_nw", 32'(dst[11][8]), 32'h7F);
`else
        run_pass(-1);
        check_val("bb_n",  32'(dst[0][5]), 32'h7F);
        check_val("bb_ne", 32'(dst[0][6]), 32'h7F);
        check_val("bb_w",  32'(dst[0][3]), 32'h7F);
        check_val("bb_nw", 32'(dst[0][4]), 32'h7F);
        check_val("bb_sw", 32'(dst[0][2]), 32'h7F);
`endif
        check_val("corner_e", 32'(dst[1][3]), 32'h7F);
        check_val("corner_s", 32'(dst[4][5]), 32'h7F);

        // Uniform lattice with a spurious start mid-pass.
        for (int c = 0; c < 16; c++)
            for (int d = 0; d < 9; d++) src[c][d] = 8'h0A;
        run_pass(50);

        // Reset mid-pass, then a fresh random pass.
        fill_random();
        abort_pass();
        @(negedge clk); #1;
        fill_random();
        run_pass(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lattice_streamer.md
Name: lattice_streamer

Overview:
- Performs the LBM streaming step, running directly downstream of the collision stage inside the lbm top.
- Walks the post-collision lattice BRAM in raster order, one cell at a time.
- For each source cell, scatters its 9 direction populations into the destination (ping-pong) BRAM at the neighbour cell in each direction, using byte-lane write enables.
- Edge cells are handled by bounce-back; toroidal wrap is available as a compile option.

Parameters:
- WIDTH, 205, lattice columns (x).
- HEIGHT, 154, lattice rows (y); WIDTH*HEIGHT = 31570 = BRAM_DEPTH of the lbm top.
- READ_LATENCY, 2, source BRAM read latency in cycles (1..4).
- ADDR_W, $clog2(WIDTH*HEIGHT), address width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  one-cycle pulse; begins one full streaming pass
- rd_addr_out  output  ADDR_W  source BRAM read address
- rd_data_in  input  [8:0][7:0]  source cell populations, lane order: 0 C, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW
- wr_addr_out  output  ADDR_W  destination BRAM write address
- wr_data_out  output  [8:0][7:0]  write data; only the enabled lane is meaningful, all other lanes are 0
- wr_byte_en_out  output  9  one-hot byte-lane enable
- wr_en_out  output  1  destination write strobe
- busy_out  output  1  high from start acceptance until done
- done_out  output  1  one-cycle pulse when the pass completes

Behaviour:
- Reset values: every output 0; state IDLE; x=y=0; base address 0. Reset mid-pass aborts immediately; no further writes are issued.
- Addressing: addr = y*WIDTH + x, row 0 at the top. North = y-1, east = x+1.
  - No multiplier. A running base address is kept alongside the x/y counters.
  - Neighbour address = base + dx + dy*WIDTH, with dy*WIDTH as a constant offset.
- FSM states: IDLE, READ, WAIT, SCATTER, DONE.
  - IDLE: on start_in go to READ, set busy_out=1. start_in is ignored in every other state.
  - READ (1 cycle): rd_addr_out = base. Go to WAIT.
  - WAIT (READ_LATENCY cycles): on the last WAIT cycle, rd_data_in is registered into cell_q. Go to SCATTER with dir=0.
  - SCATTER (9 cycles, dir 0..8): one write per cycle with wr_en_out=1, wr_byte_en_out = 1<<lane, wr_data_out[lane] = cell_q[dir].
    - Interior target: address = neighbour(dir), lane = dir.
    - Target outside the lattice (bounce-back): address = base, lane = opp(dir). opp pairs: 1↔5, 2↔6, 3↔7, 4↔8; 0↔0.
    - dir 0 always writes to base, lane 0.
    - After dir 8: if this was the last cell (x=WIDTH-1, y=HEIGHT-1) go to DONE; otherwise advance x (wrap to 0 and increment y), increment base, go to READ.
  - DONE (1 cycle): done_out=1, busy_out=0, counters cleared. Go to IDLE.
- Outside SCATTER: wr_en_out=0 and wr_byte_en_out=0.
- Timing:
  - Cell period = READ_LATENCY+10 cycles.
  - Pass length = WIDTH*HEIGHT*(READ_LATENCY+10) cycles from the first READ cycle; done_out follows in the next cycle.
- Each destination lane is written exactly once per pass. The bench checks this.
- Corner cells: both axes can be out of range at once; any diagonal leaving the lattice bounces back.
- Populations are 8-bit unsigned and pass through unmodified; no arithmetic is applied to data.

Optional Feature:
- Macro LATTICE_STREAMER_PERIODIC_WRAP_EN.
- Defined: out-of-lattice targets wrap toroidally (x mod WIDTH, y mod HEIGHT), lane = dir, no bounce-back.
- Undefined: bounce-back as above.
- Timing is identical in both builds.

Decomposition:
- Package lbm_pkg holds:
  - direction index localparams (DIR_C..DIR_NW);
  - per-direction dx/dy constant arrays;
  - OPP[9] lookup;
  - typedef cell_t = logic [8:0][7:0].
- One sub-module, lattice_neighbor_addr (combinational), maps x, y, base, dir to target address and lane, including edge and wrap handling.

Test Plan (WIDTH=4, HEIGHT=3, READ_LATENCY=2):
- Single interior cell (1,1), source lanes = 10·dir → dest addr 1 lane1 = 10; addr 6 lane3 = 30; addr 9 lane5 = 50; addr 5 lane0 = 0.
- Corner cell (0,0), lanes = 8'h7F → N, NE, W, NW, SW bounce into addr 0 lanes 5, 6, 3, 4, 2; E lands at addr 1 lane 3; S lands at addr 4 lane 5.
- Full pass of all-uniform 8'h0A lattice → every destination lane = 8'h0A; exactly 12·9 = 108 writes; done_out exactly at cycle 144 after the first READ.
- start_in pulsed again mid-pass → ignored; write count and done timing unchanged.
- rst_in asserted during SCATTER of cell 5 → next cycle all outputs 0; no writes; a fresh start_in then completes a normal pass.
- With LATTICE_STREAMER_PERIODIC_WRAP_EN defined: cell (0,0) lane 7 = 8'h33 → written to addr 3 lane 7; NW lane → addr 11 lane 8.
